// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous-read word memory between
// a fetch port (port 0, reads only) and a data port (port 1, read/write).
// One access per cycle. Read data returns to its owner one cycle after the grant.
// Build option: define ROUND_ROBIN_EN to alternate contended grants.
// Without it, port 1 has fixed priority and a starvation override protects fetch.
module imem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              stall0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero STARVE_MAX still needs a legal 1-bit counter; it simply never leaves 0.
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             rd_own0;
  logic             rd_own1;
  logic             win0;
  logic             win1;

`ifdef ROUND_ROBIN_EN
  logic             last_gnt;

  // Contended cycles go to the port that was not granted most recently.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (req0 && req1) begin
      win1 = (last_gnt == 1'b0);
      win0 = (last_gnt == 1'b1);
    end else begin
      win0 = req0;
      win1 = req1;
    end
  end

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b0;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end else begin
      last_gnt <= last_gnt;
    end
  end
`else
  logic             force0;

  // Data port wins ties unless fetch has been denied STARVE_MAX cycles in a row.
  always_comb begin
    win0   = 1'b0;
    win1   = 1'b0;
    force0 = (STARVE_MAX > 0) && (starve_cnt == CNT_MAX);
    if (req0 && req1) begin
      win0 = force0;
      win1 = ~force0;
    end else begin
      win0 = req0;
      win1 = req1;
    end
  end
`endif

  // Grants and memory controls; nothing is issued while reset is held.
  always_comb begin
    gnt0      = win0 & rst;
    gnt1      = win1 & rst;
    stall0    = req0 & ~gnt0;
    mem_en    = gnt0 | gnt1;
    mem_we    = gnt1 & we1;
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = wdata1;
  end

  // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= {CNT_W{1'b0}};
    end else if (req0 && !gnt0) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else begin
      starve_cnt <= {CNT_W{1'b0}};
    end
  end

  // Record the owner of a read in flight; writes never produce a return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_own0 <= 1'b0;
      rd_own1 <= 1'b0;
    end else begin
      rd_own0 <= gnt0;
      rd_own1 <= gnt1 & ~we1;
    end
  end

  // Steer the memory read data to its owner; the other port sees zero.
  always_comb begin
    rvalid0 = rd_own0;
    rvalid1 = rd_own1;
    rdata0  = rd_own0 ? mem_rdata : {DATA_W{1'b0}};
    rdata1  = rd_own1 ? mem_rdata : {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter with a behavioural synchronous-read memory and
// a read-return scoreboard. Define ROUND_ROBIN_EN to check the alternating mode.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic [7:0]  addr0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        stall0;
  logic        req1;
  logic        we1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_checks = 0;
  int n_fail   = 0;

  imem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata1(rdata1), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro model: synchronous read, write on enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Scoreboard: pop and compare returns, then push expectations for new read grants.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst) begin
      q0.delete();
      q1.delete();
      n_checks++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_reset_rvalid: rvalid0=%b rvalid1=%b required 0 0", rvalid0, rvalid1);
      end
    end else begin
      n_checks++;
      if (q0.size() > 0) begin
        exp = q0.pop_front();
        if (rvalid0 !== 1'b1 || rdata0 !== exp) begin
          n_fail++;
          $display("FAIL sb_port0: rvalid0=%b rdata0=%h required 1 %h", rvalid0, rdata0, exp);
        end
      end else if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin
        n_fail++;
        $display("FAIL sb_port0_idle: rvalid0=%b rdata0=%h required 0 0", rvalid0, rdata0);
      end
      n_checks++;
      if (q1.size() > 0) begin
        exp = q1.pop_front();
        if (rvalid1 !== 1'b1 || rdata1 !== exp) begin
          n_fail++;
          $display("FAIL sb_port1: rvalid1=%b rdata1=%h required 1 %h", rvalid1, rdata1, exp);
        end
      end else if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
        n_fail++;
        $display("FAIL sb_port1_idle: rvalid1=%b rdata1=%h required 0 0", rvalid1, rdata1);
      end
      n_checks++;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        n_fail++;
        $display("FAIL sb_one_hot: gnt0=1 gnt1=1 required at most one");
      end
      if (gnt0 === 1'b1) q0.push_back(shadow[addr0]);
      if (gnt1 === 1'b1 && we1 === 1'b0) q1.push_back(shadow[addr1]);
      if (gnt1 === 1'b1 && we1 === 1'b1) shadow[addr1] = wdata1;
    end
  end

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
    addr0 = 8'h20; addr1 = 8'h30; wdata1 = 32'h0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_en !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt0=%b gnt1=%b mem_en=%b rv0=%b rv1=%b required all 0",
               gnt0, gnt1, mem_en, rvalid0, rvalid1);
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    n_checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: gnt0=%b gnt1=%b mem_en=%b required 0 1 1", gnt0, gnt1, mem_en);
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h05;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1 || stall0 !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h05) begin
      n_fail++;
      $display("FAIL fetch_grant: gnt0=%b stall0=%b mem_en=%b mem_addr=%h required 1 0 1 05",
               gnt0, stall0, mem_en, mem_addr);
    end
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_data: rvalid0=%b rdata0=%h required 1 deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention();
    logic exp0;
    @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h20; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
    for (int k = 0; k < 9; k++) begin
`ifdef ROUND_ROBIN_EN
      exp0 = (k % 2 == 1);
`else
      exp0 = (k == 4);
`endif
      @(negedge clk);
      n_checks++;
      if (gnt0 !== exp0 || gnt1 !== !exp0 || stall0 !== !exp0) begin
        n_fail++;
        $display("FAIL contention_c%0d: gnt0=%b gnt1=%b stall0=%b required %b %b %b",
                 k, gnt0, gnt1, stall0, exp0, !exp0, !exp0);
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_grant: gnt1=%b mem_we=%b mem_addr=%h mem_wdata=%h required 1 1 10 12345678",
               gnt1, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1 we1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1 || mem_we !== 1'b0 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: gnt1=%b mem_we=%b rvalid1=%b required 1 0 0", gnt1, mem_we, rvalid1);
    end
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_read_data: rvalid1=%b rdata1=%h required 1 12345678", rvalid1, rdata1);
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h05;
    @(negedge clk);
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrd_grant: gnt0=%b required 1", gnt0);
    end
    #1 rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrd_in_reset: rvalid0=%b gnt0=%b required 0 0", rvalid0, gnt0);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL midrd_after_release%0d: rvalid0=%b required 0", k, rvalid0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'hA5000000 | 32'(i);
      shadow[i] = 32'hA5000000 | 32'(i);
    end
    mem[5]    = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    test_reset();
    test_fetch();
    test_contention();
    test_write_read();
    test_reset_mid_read();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
